// File: rtl/dmem_lsu_if.sv
// rtl/dmem_lsu_if.sv - request/response handshake bundle for the dmem_lsu data memory
interface dmem_lsu_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [2:0]        req_funct3;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_funct3,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_funct3,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - handshaked RV32 data memory with byte/half/word sizing and error reporting
// Optional feature: DMEM_MISALIGN_TRAP_EN (misaligned accesses error instead of being force-aligned)
module dmem_lsu #(
  parameter int NUM_WORDS = 1024,
  parameter int ADDR_W    = 32,
  parameter int LATENCY   = 1
) (
  input logic       clk,
  input logic       n_rst,
  dmem_lsu_if.slave bus
);
  localparam int IDX_W  = ADDR_W - 2;
  localparam int MEM_AW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic              ready_q;
  logic              resp_valid_q;
  logic [31:0]       resp_rdata_q;
  logic              resp_err_q;
  logic              l_we;
  logic [ADDR_W-1:0] l_addr;
  logic [31:0]       l_wdata;
  logic [2:0]        l_funct3;
  logic [31:0]       mem [NUM_WORDS];

  logic              accept;
  logic              enter_resp;
  logic              c_we;
  logic [ADDR_W-1:0] c_addr;
  logic [31:0]       c_wdata;
  logic [2:0]        c_funct3;
  logic [IDX_W-1:0]  idx;
  logic [MEM_AW-1:0] widx;
  logic [1:0]        lane;
  logic              f3_bad;
  logic              oor;
  logic              trap_misal;
  logic              err;
  logic [31:0]       word;
  logic [7:0]        sel_b;
  logic [15:0]       sel_h;
  logic [31:0]       ld_data;
  logic [31:0]       wmask;
  logic [31:0]       wrep;
  logic [31:0]       new_word;

  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;

  assign accept     = bus.req_valid && ready_q;
  assign enter_resp = ((state == IDLE) && accept && (LATENCY == 1)) ||
                      ((state == WAIT) && (cnt == 4'd1));

  // With LATENCY=1 the access completes on the accept edge, so decode the live request in IDLE.
  always_comb begin
    if (state == IDLE) begin
      c_we     = bus.req_we;
      c_addr   = bus.req_addr;
      c_wdata  = bus.req_wdata;
      c_funct3 = bus.req_funct3;
    end else begin
      c_we     = l_we;
      c_addr   = l_addr;
      c_wdata  = l_wdata;
      c_funct3 = l_funct3;
    end
  end

  always_comb begin
    lane       = c_addr[1:0];
    trap_misal = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
    if (c_funct3[1:0] == 2'd1)
      trap_misal = lane[0];
    else if (c_funct3[1:0] == 2'd2)
      trap_misal = (lane != 2'd0);
`else
    if (c_funct3[1:0] == 2'd1)
      lane[0] = 1'b0;
    else if (c_funct3[1:0] == 2'd2)
      lane = 2'd0;
`endif
    f3_bad = c_we ? (c_funct3 > 3'd2) : ((c_funct3 == 3'd3) || (c_funct3 > 3'd5));
    idx    = c_addr[ADDR_W-1:2];
    oor    = (64'(idx) >= 64'(NUM_WORDS));
    widx   = idx[MEM_AW-1:0];
    err    = f3_bad || oor || trap_misal;
    word   = mem[widx];
  end

  always_comb begin
    sel_b = word[{lane, 3'b000} +: 8];
    sel_h = lane[1] ? word[31:16] : word[15:0];
    case (c_funct3)
      3'd0:    ld_data = {{24{sel_b[7]}}, sel_b};
      3'd4:    ld_data = {24'd0, sel_b};
      3'd1:    ld_data = {{16{sel_h[15]}}, sel_h};
      3'd5:    ld_data = {16'd0, sel_h};
      default: ld_data = word;
    endcase
    case (c_funct3[1:0])
      2'd0: begin
        wmask = 32'h0000_00FF << {lane, 3'b000};
        wrep  = {4{c_wdata[7:0]}};
      end
      2'd1: begin
        wmask = lane[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
        wrep  = {2{c_wdata[15:0]}};
      end
      default: begin
        wmask = 32'hFFFF_FFFF;
        wrep  = c_wdata;
      end
    endcase
    new_word = (word & ~wmask) | (wrep & wmask);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
      l_we         <= 1'b0;
      l_addr       <= '0;
      l_wdata      <= 32'd0;
      l_funct3     <= 3'd0;
      for (int i = 0; i < NUM_WORDS; i++) mem[i] <= 32'd0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            l_we     <= bus.req_we;
            l_addr   <= bus.req_addr;
            l_wdata  <= bus.req_wdata;
            l_funct3 <= bus.req_funct3;
            ready_q  <= 1'b0;
            if (LATENCY == 1) begin
              state        <= RESP;
              resp_valid_q <= 1'b1;
            end else begin
              state <= WAIT;
              cnt   <= 4'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state        <= RESP;
            resp_valid_q <= 1'b1;
          end
        end
        RESP: begin
          state   <= IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
      if (enter_resp) begin
        resp_err_q   <= err;
        resp_rdata_q <= (err || c_we) ? 32'd0 : ld_data;
        if (!err && c_we) mem[widx] <= new_word;
      end
    end
  end
endmodule

// File: tb/tb_dmem_lsu.sv
// tb/tb_dmem_lsu.sv - table-driven scoreboard bench for dmem_lsu (LATENCY=4 main unit, LATENCY=1 small unit)
module tb_dmem_lsu;
`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  int   passed = 0;
  int   total = 0;
  vec_t vecs[$];
  logic [32:0] exp_q[$];

  dmem_lsu_if #(.ADDR_W(32)) b4 ();
  dmem_lsu_if #(.ADDR_W(32)) b1 ();

  dmem_lsu #(.NUM_WORDS(1024), .ADDR_W(32), .LATENCY(4)) dut4 (.clk(clk), .n_rst(n_rst), .bus(b4));
  dmem_lsu #(.NUM_WORDS(5), .ADDR_W(32), .LATENCY(1)) dut1 (.clk(clk), .n_rst(n_rst), .bus(b1));

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  task automatic set_req(input int s, input logic v, input logic we, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [2:0] f3);
    if (s == 1) begin
      b1.req_valid = v; b1.req_we = we; b1.req_addr = addr; b1.req_wdata = wd; b1.req_funct3 = f3;
    end else begin
      b4.req_valid = v; b4.req_we = we; b4.req_addr = addr; b4.req_wdata = wd; b4.req_funct3 = f3;
    end
  endtask

  function automatic logic rdy(input int s);
    return (s == 1) ? b1.req_ready : b4.req_ready;
  endfunction
  function automatic logic rv(input int s);
    return (s == 1) ? b1.resp_valid : b4.resp_valid;
  endfunction
  function automatic logic [31:0] rd(input int s);
    return (s == 1) ? b1.resp_rdata : b4.resp_rdata;
  endfunction
  function automatic logic re(input int s);
    return (s == 1) ? b1.resp_err : b4.resp_err;
  endfunction

  task automatic add(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [2:0] f3, input logic [31:0] er, input logic ee);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wd; v.f3 = f3; v.rdata = er; v.err = ee;
    vecs.push_back(v);
  endtask

  // Called at a negedge; returns at the negedge after the response strobe.
  task automatic do_req(input int s, input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [2:0] f3, input logic [31:0] er, input logic ee, input string nm);
    int n;
    int lat;
    logic [32:0] e;
    lat = (s == 1) ? 1 : 4;
    exp_q.push_back({ee, er});
    set_req(s, 1'b1, we, addr, wd, f3);
    n = 0;
    while (!rdy(s) && n < 50) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    set_req(s, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    check({nm, " busy"}, 32'(rdy(s)), 32'd0);
    n = 1;
    while (!rv(s) && n < 40) begin @(negedge clk); n++; end
    check({nm, " latency"}, 32'(n), 32'(lat));
    e = exp_q.pop_front();
    check({nm, " rdata"}, rd(s), e[31:0]);
    check({nm, " err"}, 32'(re(s)), 32'(e[32]));
    @(negedge clk);
  endtask

  initial begin
    int n;
    logic got_first;
    logic [31:0] w10;

    w10 = TRAP ? 32'hDEAD_55EF : 32'h1234_55EF;
    add(0, 32'h000, 0, 3'd2, 32'h0000_0000, 0);
    add(1, 32'h010, 32'hDEAD_BEEF, 3'd2, 0, 0);
    add(1, 32'h011, 32'h0000_0055, 3'd0, 0, 0);
    add(0, 32'h011, 0, 3'd4, 32'h0000_0055, 0);
    add(0, 32'h013, 0, 3'd0, 32'hFFFF_FFDE, 0);
    add(0, 32'h010, 0, 3'd2, 32'hDEAD_55EF, 0);
    add(0, 32'h010, 0, 3'd0, 32'hFFFF_FFEF, 0);
    add(0, 32'h012, 0, 3'd4, 32'h0000_00AD, 0);
    add(0, 32'h012, 0, 3'd1, 32'hFFFF_DEAD, 0);
    add(0, 32'h011, 0, 3'd1, TRAP ? 32'h0 : 32'h0000_55EF, TRAP);
    add(1, 32'h013, 32'h0000_1234, 3'd1, 0, TRAP);
    add(0, 32'h010, 0, 3'd2, w10, 0);
    add(1, 32'h022, 32'h0000_8001, 3'd1, 0, 0);
    add(0, 32'h022, 0, 3'd1, 32'hFFFF_8001, 0);
    add(0, 32'h022, 0, 3'd5, 32'h0000_8001, 0);
    add(0, 32'h020, 0, 3'd5, 32'h0000_0000, 0);
    add(0, 32'h020, 0, 3'd2, 32'h8001_0000, 0);
    add(1, 32'h006, 32'h1234_5678, 3'd2, 0, TRAP);
    add(0, 32'h004, 0, 3'd2, TRAP ? 32'h0 : 32'h1234_5678, 0);
    add(1, 32'hFFC, 32'hA5A5_A5A5, 3'd2, 0, 0);
    add(0, 32'hFFC, 0, 3'd2, 32'hA5A5_A5A5, 0);
    add(1, 32'h1000, 32'h1111_1111, 3'd2, 0, 1);
    add(0, 32'h1000, 0, 3'd2, 0, 1);
    add(1, 32'h030, 32'hFFFF_FFFF, 3'd4, 0, 1);
    add(1, 32'h030, 32'hFFFF_FFFF, 3'd3, 0, 1);
    add(0, 32'h030, 0, 3'd2, 32'h0000_0000, 0);
    add(0, 32'h010, 0, 3'd3, 0, 1);
    add(0, 32'h010, 0, 3'd7, 0, 1);

    set_req(0, 0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    check("reset ready", 32'(b4.req_ready), 32'd1);
    check("reset resp_valid", 32'(b4.resp_valid), 32'd0);
    check("reset rdata", b4.resp_rdata, 32'd0);
    check("reset err", 32'(b4.resp_err), 32'd0);

    for (int i = 0; i < vecs.size(); i++)
      do_req(0, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].f3, vecs[i].rdata, vecs[i].err,
             $sformatf("vec%0d", i));

    // Request held through RESP: new fields after accept must be ignored until IDLE returns.
    set_req(0, 1, 0, 32'h010, 0, 3'd2);
    @(posedge clk);
    @(negedge clk);
    set_req(0, 1, 0, 32'h011, 0, 3'd4);
    n = 0;
    got_first = 1'b0;
    while (!rdy(0) && n < 50) begin
      if (rv(0)) begin
        check("held first rdata", rd(0), w10);
        got_first = 1'b1;
      end
      @(negedge clk);
      n++;
    end
    check("held gap", 32'(n), 32'd4);
    check("held first seen", 32'(got_first), 32'd1);
    @(posedge clk);
    @(negedge clk);
    set_req(0, 0, 0, 0, 0, 0);
    n = 1;
    while (!rv(0) && n < 40) begin @(negedge clk); n++; end
    check("held second latency", 32'(n), 32'd4);
    check("held second rdata", rd(0), 32'h0000_0055);
    repeat (3) @(negedge clk);
    check("hold rdata", b4.resp_rdata, 32'h0000_0055);
    check("hold valid low", 32'(b4.resp_valid), 32'd0);

    do_req(1, 1, 32'h010, 32'h1122_3344, 3'd2, 0, 0, "l1 sw");
    do_req(1, 0, 32'h010, 0, 3'd2, 32'h1122_3344, 0, "l1 lw");
    do_req(1, 0, 32'h012, 0, 3'd1, 32'h0000_1122, 0, "l1 lh");
    do_req(1, 0, 32'h013, 0, 3'd0, 32'h0000_0011, 0, "l1 lb");
    do_req(1, 1, 32'h014, 32'hFFFF_FFFF, 3'd2, 0, 1, "l1 sw oor");
    do_req(1, 0, 32'h014, 0, 3'd2, 0, 1, "l1 lw oor");
    do_req(1, 0, 32'h000, 0, 3'd4, 0, 0, "l1 lbu 0");

    // Reset during WAIT of a store drops it entirely.
    set_req(0, 1, 1, 32'h040, 32'hCAFE_F00D, 3'd2);
    @(posedge clk);
    @(negedge clk);
    set_req(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_rst = 1'b0;
    #1;
    check("midreset ready", 32'(b4.req_ready), 32'd1);
    check("midreset valid", 32'(b4.resp_valid), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    check("postreset ready", 32'(b4.req_ready), 32'd1);
    do_req(0, 0, 32'h040, 0, 3'd2, 32'h0000_0000, 0, "postreset lw 0x40");
    do_req(0, 0, 32'h010, 0, 3'd2, 32'h0000_0000, 0, "postreset lw 0x10");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
